// File: rtl/im_loader_pkg.sv
// im_loader_pkg: state encoding and checksum rule for the IM program loader.
package im_loader_pkg;

    // Loader sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Checksum step: sum = rotl(sum, CSUM_ROT) ^ word
    localparam int CSUM_ROT = 1;

endpackage

// File: rtl/im_loader_csum.sv
// im_loader_csum: rotate/xor checksum accumulator with synchronous clear and enable.
// sum_nxt exposes the value the accumulator would take this cycle, so a caller
// can compare against the final sum on the same edge the last word arrives.
module im_loader_csum
    import im_loader_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sum,
    output logic [W-1:0] sum_nxt
);

    assign sum_nxt = ((sum << CSUM_ROT) | (sum >> (W - CSUM_ROT))) ^ din;

    // Accumulate one word per enabled cycle; clear wins over enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum_nxt;
        end
    end

endmodule

// File: rtl/im_loader.sv
// im_loader: writes a stream of instruction words into IM from address 0 while
// holding the core in reset, then releases the core.
// Optional readback check of the loaded image: define IM_LOADER_VERIFY_EN.
// Stream handshake: a word transfers on every rising edge where s_valid and
// s_ready are both 1; s_ready depends only on state, never on s_valid, and the
// source must hold s_data stable while s_valid=1 and s_ready=0.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int DataSize   = 32,
    parameter int IMAddrSize = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IMAddrSize:0]   prog_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DataSize-1:0]   s_data,
    output logic                  IM_enable,
    output logic                  IM_write,
    output logic                  IM_read,
    output logic [IMAddrSize-1:0] IM_address,
    output logic [DataSize-1:0]   IM_in,
    input  logic [DataSize-1:0]   IM_out,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [IMAddrSize:0]   words_written,
    output logic [DataSize-1:0]   checksum,
    output state_t                state_dbg
);

    localparam logic [IMAddrSize:0] MAX_LEN = {1'b1, {IMAddrSize{1'b0}}};
    localparam logic [IMAddrSize:0] CNT_ONE = {{IMAddrSize{1'b0}}, 1'b1};

    state_t              state;
    logic [IMAddrSize:0] len;
    logic [IMAddrSize:0] wr_cnt;
    logic                start_ok;
    logic                accept;
    logic [DataSize-1:0] unused_wr_nxt;

    assign s_ready   = (state == ST_LOAD);
    assign accept    = s_valid && s_ready;
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign state_dbg = state;

    im_loader_csum #(.W(DataSize)) u_wr_csum (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .en      (accept),
        .din     (s_data),
        .sum     (checksum),
        .sum_nxt (unused_wr_nxt)
    );

`ifdef IM_LOADER_VERIFY_EN
    logic [IMAddrSize:0] rd_cnt;
    logic                ret_vld;
    logic [DataSize-1:0] unused_rb_sum;
    logic [DataSize-1:0] rb_nxt;
    logic                mismatch;

    im_loader_csum #(.W(DataSize)) u_rb_csum (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .en      (ret_vld),
        .din     (IM_out),
        .sum     (unused_rb_sum),
        .sum_nxt (rb_nxt)
    );

    // Compared on the edge that folds in the last returned word
    assign mismatch = (rb_nxt != checksum);

    // IM_out carries read data the cycle after IM samples a read request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ret_vld <= 1'b0;
        end else begin
            ret_vld <= IM_read;
        end
    end
`else
    logic unused_im_out;
    assign unused_im_out = ^IM_out;
`endif

    // Load sequencer: start handling, stream-to-IM writes, readback, status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            len           <= '0;
            wr_cnt        <= '0;
            IM_enable     <= 1'b0;
            IM_write      <= 1'b0;
            IM_read       <= 1'b0;
            IM_address    <= '0;
            IM_in         <= '0;
            cpu_hold      <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
`ifdef IM_LOADER_VERIFY_EN
            rd_cnt        <= '0;
`endif
        end else begin
            IM_enable <= 1'b0;
            IM_write  <= 1'b0;
            IM_read   <= 1'b0;
            // A write registered last cycle commits in IM on this edge
            if (IM_write) begin
                words_written <= words_written + CNT_ONE;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        done          <= 1'b0;
                        error         <= 1'b0;
                        cpu_hold      <= 1'b1;
                        words_written <= '0;
                        wr_cnt        <= '0;
                        len           <= prog_len;
                        if (prog_len == '0) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (prog_len > MAX_LEN) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        IM_enable  <= 1'b1;
                        IM_write   <= 1'b1;
                        IM_address <= wr_cnt[IMAddrSize-1:0];
                        IM_in      <= s_data;
                        wr_cnt     <= wr_cnt + CNT_ONE;
                        if (wr_cnt == len - CNT_ONE) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
`ifdef IM_LOADER_VERIFY_EN
                    // Final write commits now; the first read is sampled next edge
                    state      <= ST_VERIFY;
                    IM_enable  <= 1'b1;
                    IM_read    <= 1'b1;
                    IM_address <= '0;
                    rd_cnt     <= CNT_ONE;
`else
                    state    <= ST_DONE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    cpu_hold <= 1'b0;
`endif
                end
`ifdef IM_LOADER_VERIFY_EN
                ST_VERIFY: begin
                    if (rd_cnt != len) begin
                        IM_enable  <= 1'b1;
                        IM_read    <= 1'b1;
                        IM_address <= rd_cnt[IMAddrSize-1:0];
                        rd_cnt     <= rd_cnt + CNT_ONE;
                    end else if (ret_vld && !IM_read) begin
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        error    <= mismatch;
                        cpu_hold <= mismatch;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
